pe: RTL and testbench
=====================

Name: pe

Overview:
- Convolution processing element for a 1-D/row-stationary CNN accelerator.
- Buffers an input-feature-map (IFM) row, up to FIL_DEPTH filter taps and optional partial sums, then computes signed dot products of sliding windows against one or several filters.
- Results go into an output FIFO, drained one per read request.
- Sits between the global buffer and the accumulation network.

Parameters:
- DATA_WIDTH, 16: operand width (signed two's complement).
- ADDR_WIDTH_IFM, 4: IFM buffer address bits (depth 2^4 = 16).
- ADDR_WIDTH_FIL, 5: psum buffer and output FIFO address bits (depth 32 each).
- S, 3: stride field width.
- F, 4: filter_size field width.
- PAR_WRITE, 1: operands per write (only 1 supported).
- PAR_READ, 1: results per read (only 1 supported).
- FIL_DEPTH, 6: filter buffer capacity in taps.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  rising edge arms a new job.
- r_en  in  1  rising edge pops one result.
- w_en_ifm  in  1  rising edge writes data_in_ifm.
- w_en_fil  in  1  rising edge writes data_in_fil.
- w_en_psum  in  1  rising edge writes data_in_psum.
- acum  in  1  sampled at start; 1 = add psum to each result.
- data_in_ifm  in  DATA_WIDTH*PAR_WRITE+2
  - [MSB] = first-of-row flag; [MSB-1] = last-of-row flag; low bits = pixel.
- data_in_fil  in  DATA_WIDTH*PAR_WRITE  filter tap.
- data_in_psum  in  DATA_WIDTH  signed partial sum.
- stride  in  S  window step; 0 is treated as 1.
- filter_size  in  F  taps per filter K, 1..FIL_DEPTH.
- mode  in  2
  - 00/01: single filter (taps 0..K-1).
  - 10: multi-filter, window-major output order.
  - 11: multi-filter, filter-major output order.
- out  out  (2*DATA_WIDTH-1)*PAR_READ  registered result.
- done  out  1  high from job completion until next start or reset.
- valid  out  1  one-cycle pulse when out is updated.
- ready_ifm / ready_fil / ready_psum  out  1  respective buffer not full.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: out=0, valid=0, done=0, readies=1.
  - All pointers and counters cleared; FSM returns to IDLE.
  - Takes effect mid-operation; in-flight work is discarded.
- All enables are edge-detected against a registered copy; a level held for many cycles acts once. Multiple edges in the same cycle are each honoured.
- Start rising edge:
  - Clears all buffers, FIFO and done.
  - Latches stride, filter_size, mode and acum.
  - Enters RUN. A start edge while RUN restarts the job.
- Filter buffer:
  - Taps stored in write order; writes beyond FIL_DEPTH are ignored; ready_fil = count < FIL_DEPTH.
  - Number of filters NF = 1 in modes 0x, floor(FIL_DEPTH/K) in modes 1x.
  - Computation starts only once NF*K taps are present.
- IFM buffer:
  - 16-entry circular buffer; writes when full are ignored.
  - Entries below the current window base are freed.
  - A write with the first-of-row flag resets the row index to 0.
  - The last-of-row flag fixes row length N.
- Windows and output order:
  - Window w covers row indices w*stride .. w*stride+K-1.
  - Window count W = floor((N-K)/stride)+1; W = 0 if N < K.
  - Mode 10: order is w0f0, w0f1, ..., w1f0, ...
  - Mode 11: order is all windows of f0, then f1, ...
  - Mode 11 requires the whole row (N <= 16) to be buffered before starting.
- MAC timing:
  - One signed DATA_WIDTH x DATA_WIDTH multiply-accumulate per cycle.
  - The accumulator is 2*DATA_WIDTH-1 bits, wrapping modulo.
  - A K-tap result is pushed into the FIFO on the edge after its K-th MAC.
  - The datapath stalls, with no partial corruption, when needed data is absent or the FIFO is full.
- Psum:
  - 32-entry FIFO; ready_psum = not full.
  - When acum=1, each result adds the next psum entry, sign-extended; the datapath stalls if the psum FIFO is empty.
- Output FIFO and read:
  - 32-entry output FIFO.
  - On an r_en edge with the FIFO non-empty: out is loaded next cycle and valid pulses for 1 cycle.
  - On an r_en edge with the FIFO empty: nothing happens; valid stays 0 and out holds.
- Completion: done asserts the cycle after the last of W*NF results is pushed; the FSM returns to IDLE.
  - K=0 or K>FIL_DEPTH completes immediately with zero results.

Test Plan:
- Mode 00, K=3, stride 1, filter {1,2,3}, IFM {1,2,3,4,5} (flags 10,00,00,00,01), five reads -> outputs 14, 20, 26; done=1; 4th and 5th reads give valid=0.
- Mode 10, K=3, six taps {1,2,3,1,0,-1}, IFM {1,2,3,4} -> 14, -2, 20, -2; mode 11 with the same data -> 14, 20, -2, -2.
- Stride 2, mode 00, filter {1,2,3}, IFM {1..5} -> 14, 26; the window at base 1 is skipped.
- acum=1, psum {100,200,300}, mode 00, filter {1,2,3}, IFM {1..5} -> 114, 220, 326; with the psum FIFO empty, no result appears until psum is written.
- Edge detection: w_en_ifm held 20 cycles writes exactly one entry; a 7th filter write is ignored with ready_fil=0; r_en held 120 cycles pops exactly one result.
- rst_n pulsed low mid-computation -> outputs at reset values immediately; a new start/load sequence then yields correct results.

Source files
------------

// File: rtl/pe_if.sv
// pe_if: bus bundle between the global buffer and one processing element
// master drives loads/control, slave (the PE) returns results and readies
interface pe_if #(
  parameter int DW = 16,
  parameter int PW = 1,
  parameter int PR = 1,
  parameter int S  = 3,
  parameter int F  = 4
);
  logic                  start;
  logic                  r_en;
  logic                  w_en_ifm;
  logic                  w_en_fil;
  logic                  w_en_psum;
  logic                  acum;
  logic [DW*PW+1:0]      data_in_ifm;
  logic [DW*PW-1:0]      data_in_fil;
  logic [DW-1:0]         data_in_psum;
  logic [S-1:0]          stride;
  logic [F-1:0]          filter_size;
  logic [1:0]            mode;
  logic [(2*DW-1)*PR-1:0] out;
  logic                  done;
  logic                  valid;
  logic                  ready_ifm;
  logic                  ready_fil;
  logic                  ready_psum;

  modport master (
    output start, r_en, w_en_ifm, w_en_fil, w_en_psum, acum,
    output data_in_ifm, data_in_fil, data_in_psum,
    output stride, filter_size, mode,
    input  out, done, valid, ready_ifm, ready_fil, ready_psum
  );

  modport slave (
    input  start, r_en, w_en_ifm, w_en_fil, w_en_psum, acum,
    input  data_in_ifm, data_in_fil, data_in_psum,
    input  stride, filter_size, mode,
    output out, done, valid, ready_ifm, ready_fil, ready_psum
  );
endinterface

// File: rtl/pe.sv
// pe: convolution processing element
// buffers an IFM row, filter taps and psums; MACs sliding windows into a FIFO
module pe #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH_IFM = 4,
  parameter int ADDR_WIDTH_FIL = 5,
  parameter int S              = 3,
  parameter int F              = 4,
  parameter int PAR_WRITE      = 1,
  parameter int PAR_READ       = 1,
  parameter int FIL_DEPTH      = 6
) (
  input logic clk,
  input logic rst_n,
  pe_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int PX = DATA_WIDTH * PAR_WRITE;
  localparam int AW = 2 * DW - 1;
  localparam int OW = AW * PAR_READ;
  localparam int AI = ADDR_WIDTH_IFM;
  localparam int AP = ADDR_WIDTH_FIL;
  localparam int IW = AI + 4;
  localparam int CW = $clog2(FIL_DEPTH + 1);
  localparam int FA = $clog2(FIL_DEPTH);
  localparam int XW = 8;
  localparam logic [IW-1:0] IDEPTH = IW'(1 << AI);
  localparam logic [AP:0]   PDEPTH = (AP + 1)'(1 << AP);
  localparam logic [CW-1:0] FDEPTH = CW'(FIL_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;
  logic start_q, ren_q, wifm_q, wfil_q, wpsum_q;
  logic start_e, ren_e, wifm_e, wfil_e, wpsum_e;
  logic [S-1:0] stride_q, stride_d;
  logic [F-1:0] k_q, k_d, nf_q, nf_d, t_q, t_d, f_q, f_d;
  logic [1:0] mode_q, mode_d;
  logic acum_q, acum_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic [IW-1:0] wr_q, wr_d, n_q, n_d, base_q, base_d;
  logic nv_q, nv_d;
  logic [AP:0] pwr_q, pwr_d, prd_q, prd_d, owr_q, owr_d, ord_q, ord_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [OW-1:0] out_q, out_d;
  logic valid_q, valid_d, done_q, done_d;

  logic [DW-1:0] fil_mem [FIL_DEPTH];
  logic [DW-1:0] ifm_mem [1 << AI];
  logic [DW-1:0] ps_mem  [1 << AP];
  logic [AW-1:0] of_mem  [1 << AP];

  logic fil_we, ifm_we, ps_we, of_we;
  logic [FA-1:0] fil_wa, fa;
  logic [AI-1:0] ifm_wa;
  logic [AP-1:0] ps_wa;
  logic [IW-1:0] wa, idx, fb;
  logic [F-1:0] kdiv, nf_in;
  logic fm, ifm_full, ps_full, ps_empty, of_full, of_empty;
  logic have_fil, have_ifm, last_tap, can_push, row_end, k_bad;
  logic [DW-1:0] px, tw, ps;
  logic [AW-1:0] pxs, tws, psx, prod, sum, res;

  assign start_e = bus.start & ~start_q;
  assign ren_e   = bus.r_en & ~ren_q;
  assign wifm_e  = bus.w_en_ifm & ~wifm_q;
  assign wfil_e  = bus.w_en_fil & ~wfil_q;
  assign wpsum_e = bus.w_en_psum & ~wpsum_q;

  assign kdiv  = (bus.filter_size == '0) ? F'(1) : bus.filter_size;
  assign nf_in = bus.mode[1] ? F'(FIL_DEPTH / int'(kdiv)) : F'(1);

  assign fm       = mode_q == 2'b11;
  assign fb       = fm ? '0 : base_q;
  assign ifm_full = (wr_q > fb) && ((wr_q - fb) >= IDEPTH);
  assign ps_full  = (pwr_q - prd_q) == PDEPTH;
  assign ps_empty = pwr_q == prd_q;
  assign of_full  = (owr_q - ord_q) == PDEPTH;
  assign of_empty = owr_q == ord_q;

  assign k_bad    = (k_q == '0) || (int'(k_q) > FIL_DEPTH);
  assign idx      = base_q + IW'(t_q);
  assign fa       = FA'(f_q) * FA'(k_q) + FA'(t_q);
  assign have_fil = XW'(fcnt_q) >= XW'(nf_q) * XW'(k_q);
  assign have_ifm = (idx < wr_q) && (!fm || nv_q);
  assign last_tap = t_q == k_q - F'(1);
  assign can_push = !of_full && (!acum_q || !ps_empty);
  assign row_end  = nv_q &&
                    (({1'b0, base_q} + (IW + 1)'(k_q)) > {1'b0, n_q});

  assign px   = ifm_mem[idx[AI-1:0]];
  assign tw   = fil_mem[fa];
  assign ps   = ps_mem[prd_q[AP-1:0]];
  assign pxs  = {{(AW - DW){px[DW-1]}}, px};
  assign tws  = {{(AW - DW){tw[DW-1]}}, tw};
  assign psx  = {{(AW - DW){ps[DW-1]}}, ps};
  assign prod = pxs * tws;
  assign sum  = acc_q + prod;
  assign res  = sum + (acum_q ? psx : '0);

  assign bus.out        = out_q;
  assign bus.valid      = valid_q;
  assign bus.done       = done_q;
  assign bus.ready_ifm  = !ifm_full;
  assign bus.ready_fil  = fcnt_q < FDEPTH;
  assign bus.ready_psum = !ps_full;

  // next state: job control, MAC sequencing, buffer writes and FIFO reads
  always_comb begin
    state_d  = state_q;
    stride_d = stride_q;
    k_d      = k_q;
    nf_d     = nf_q;
    t_d      = t_q;
    f_d      = f_q;
    mode_d   = mode_q;
    acum_d   = acum_q;
    fcnt_d   = fcnt_q;
    wr_d     = wr_q;
    n_d      = n_q;
    base_d   = base_q;
    nv_d     = nv_q;
    pwr_d    = pwr_q;
    prd_d    = prd_q;
    owr_d    = owr_q;
    ord_d    = ord_q;
    acc_d    = acc_q;
    out_d    = out_q;
    valid_d  = 1'b0;
    done_d   = done_q;
    fil_we   = 1'b0;
    fil_wa   = '0;
    ifm_we   = 1'b0;
    ifm_wa   = '0;
    ps_we    = 1'b0;
    ps_wa    = '0;
    of_we    = 1'b0;
    wa       = '0;
    if (start_e) begin
      state_d  = RUN;
      stride_d = (bus.stride == '0) ? S'(1) : bus.stride;
      k_d      = bus.filter_size;
      nf_d     = nf_in;
      mode_d   = bus.mode;
      acum_d   = bus.acum;
      fcnt_d   = '0;
      wr_d     = '0;
      n_d      = '0;
      nv_d     = 1'b0;
      base_d   = '0;
      t_d      = '0;
      f_d      = '0;
      acc_d    = '0;
      pwr_d    = '0;
      prd_d    = '0;
      owr_d    = '0;
      ord_d    = '0;
      done_d   = 1'b0;
    end else if (state_q == RUN) begin
      if (k_bad ||
          (t_q == '0 && row_end &&
           (fm ? (base_q == '0 || f_q == nf_q - F'(1)) : f_q == '0))) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else if (t_q == '0 && row_end && fm) begin
        f_d    = f_q + F'(1);
        base_d = '0;
      end else if (have_fil && have_ifm && (!last_tap || can_push)) begin
        if (last_tap) begin
          of_we = 1'b1;
          owr_d = owr_q + 1'b1;
          acc_d = '0;
          t_d   = '0;
          if (acum_q) prd_d = prd_q + 1'b1;
          if (fm) begin
            base_d = base_q + IW'(stride_q);
          end else if (f_q == nf_q - F'(1)) begin
            f_d    = '0;
            base_d = base_q + IW'(stride_q);
          end else begin
            f_d = f_q + F'(1);
          end
        end else begin
          acc_d = sum;
          t_d   = t_q + F'(1);
        end
      end
    end
    if (wfil_e && fcnt_d < FDEPTH) begin
      fil_we = 1'b1;
      fil_wa = FA'(fcnt_d);
      fcnt_d = fcnt_d + CW'(1);
    end
    if (wifm_e && (start_e || !ifm_full)) begin
      wa     = bus.data_in_ifm[PX+1] ? '0 : wr_d;
      ifm_we = 1'b1;
      ifm_wa = wa[AI-1:0];
      wr_d   = wa + IW'(1);
      if (bus.data_in_ifm[PX]) begin
        n_d  = wa + IW'(1);
        nv_d = 1'b1;
      end
    end
    if (wpsum_e && (start_e || !ps_full)) begin
      ps_we = 1'b1;
      ps_wa = pwr_d[AP-1:0];
      pwr_d = pwr_d + 1'b1;
    end
    if (ren_e && !start_e && !of_empty) begin
      out_d   = OW'(of_mem[ord_q[AP-1:0]]);
      valid_d = 1'b1;
      ord_d   = ord_q + 1'b1;
    end
  end

  // buffer storage, no reset needed: pointers gate every read
  always_ff @(posedge clk) begin
    if (fil_we) fil_mem[fil_wa] <= bus.data_in_fil[DW-1:0];
    if (ifm_we) ifm_mem[ifm_wa] <= bus.data_in_ifm[DW-1:0];
    if (ps_we) ps_mem[ps_wa] <= bus.data_in_psum;
    if (of_we) of_mem[owr_q[AP-1:0]] <= res;
  end

  // state register with async clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      ren_q    <= 1'b0;
      wifm_q   <= 1'b0;
      wfil_q   <= 1'b0;
      wpsum_q  <= 1'b0;
      stride_q <= S'(1);
      k_q      <= '0;
      nf_q     <= '0;
      t_q      <= '0;
      f_q      <= '0;
      mode_q   <= '0;
      acum_q   <= 1'b0;
      fcnt_q   <= '0;
      wr_q     <= '0;
      n_q      <= '0;
      base_q   <= '0;
      nv_q     <= 1'b0;
      pwr_q    <= '0;
      prd_q    <= '0;
      owr_q    <= '0;
      ord_q    <= '0;
      acc_q    <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= bus.start;
      ren_q    <= bus.r_en;
      wifm_q   <= bus.w_en_ifm;
      wfil_q   <= bus.w_en_fil;
      wpsum_q  <= bus.w_en_psum;
      stride_q <= stride_d;
      k_q      <= k_d;
      nf_q     <= nf_d;
      t_q      <= t_d;
      f_q      <= f_d;
      mode_q   <= mode_d;
      acum_q   <= acum_d;
      fcnt_q   <= fcnt_d;
      wr_q     <= wr_d;
      n_q      <= n_d;
      base_q   <= base_d;
      nv_q     <= nv_d;
      pwr_q    <= pwr_d;
      prd_q    <= prd_d;
      owr_q    <= owr_d;
      ord_q    <= ord_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_pe.sv
// tb_pe: scoreboard bench for the convolution PE
// expected results are queued as stimulus is loaded, popped on each read
`timescale 1ns/1ps
module tb_pe;
  localparam int DW = 16;
  localparam int OW = 2 * DW - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int nvec = 0;
  int nerr = 0;
  logic [OW-1:0] sb [$];

  always #5 clk = ~clk;

  pe_if #(.DW(DW), .PW(1), .PR(1), .S(3), .F(4)) bus ();

  pe #(
    .DATA_WIDTH(DW), .ADDR_WIDTH_IFM(4), .ADDR_WIDTH_FIL(5),
    .S(3), .F(4), .PAR_WRITE(1), .PAR_READ(1), .FIL_DEPTH(6)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int st, input int k,
                           input logic [1:0] m, input logic ac);
    bus.stride      = 3'(st);
    bus.filter_size = 4'(k);
    bus.mode        = m;
    bus.acum        = ac;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
  endtask

  task automatic wr_fil(input int v);
    bus.data_in_fil = 16'(v);
    bus.w_en_fil = 1'b1;
    tick();
    bus.w_en_fil = 1'b0;
    tick();
  endtask

  task automatic wr_ifm(input int v, input logic fst, input logic lst);
    bus.data_in_ifm = {fst, lst, 16'(v)};
    bus.w_en_ifm = 1'b1;
    tick();
    bus.w_en_ifm = 1'b0;
    tick();
  endtask

  task automatic wr_ps(input int v);
    bus.data_in_psum = 16'(v);
    bus.w_en_psum = 1'b1;
    tick();
    bus.w_en_psum = 1'b0;
    tick();
  endtask

  task automatic load_row(input int n);
    for (int i = 1; i <= n; i++) wr_ifm(i, i == 1, i == n);
  endtask

  task automatic do_read(output logic v, output logic [OW-1:0] d);
    bus.r_en = 1'b1;
    tick();
    v = bus.valid;
    d = bus.out;
    bus.r_en = 1'b0;
    tick();
  endtask

  task automatic wait_done(output logic ok);
    int i;
    ok = 1'b0;
    i = 0;
    while (!ok && i < 400) begin
      if (bus.done === 1'b1) ok = 1'b1;
      else tick();
      i++;
    end
  endtask

  task automatic test_reset();
    bus.start = 0; bus.r_en = 0; bus.w_en_ifm = 0;
    bus.w_en_fil = 0; bus.w_en_psum = 0; bus.acum = 0;
    bus.data_in_ifm = '0; bus.data_in_fil = '0; bus.data_in_psum = '0;
    bus.stride = '0; bus.filter_size = '0; bus.mode = '0;
    rst_n = 1'b0;
    tick();
    tick();
    nvec++;
    if (bus.out !== '0 || bus.valid !== 1'b0 || bus.done !== 1'b0) begin
      nerr++;
      $display("FAIL reset_out: out=%0d valid=%b done=%b, want 0 0 0",
               bus.out, bus.valid, bus.done);
    end
    nvec++;
    if ({bus.ready_ifm, bus.ready_fil, bus.ready_psum} !== 3'b111) begin
      nerr++;
      $display("FAIL reset_ready: got %b%b%b, want 111",
               bus.ready_ifm, bus.ready_fil, bus.ready_psum);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic v, ok;
    logic [OW-1:0] d, e;
    start_job(1, 3, 2'b00, 1'b0);
    wr_fil(1); wr_fil(2); wr_fil(3);
    load_row(5);
    sb.push_back(31'd14); sb.push_back(31'd20); sb.push_back(31'd26);
    wait_done(ok);
    nvec++;
    if (ok !== 1'b1) begin
      nerr++;
      $display("FAIL single_done: done=%b, want 1", bus.done);
    end
    for (int i = 0; i < 3; i++) begin
      do_read(v, d);
      e = sb.pop_front();
      nvec++;
      if (v !== 1'b1 || d !== e) begin
        nerr++;
        $display("FAIL single_rd%0d: valid=%b out=%0d, want 1 %0d",
                 i, v, $signed(d), $signed(e));
      end
    end
    for (int i = 0; i < 2; i++) begin
      do_read(v, d);
      nvec++;
      if (v !== 1'b0 || d !== 31'd26 || bus.done !== 1'b1) begin
        nerr++;
        $display("FAIL single_empty%0d: valid=%b out=%0d done=%b, want 0 26 1",
                 i, v, $signed(d), bus.done);
      end
    end
  endtask

  task automatic test_multi();
    logic v, ok;
    logic [OW-1:0] d, e;
    for (int m = 0; m < 2; m++) begin
      start_job(1, 3, m == 0 ? 2'b10 : 2'b11, 1'b0);
      wr_fil(1); wr_fil(2); wr_fil(3);
      wr_fil(1); wr_fil(0); wr_fil(-1);
      load_row(4);
      if (m == 0) begin
        sb.push_back(31'd14); sb.push_back(31'(-2));
        sb.push_back(31'd20); sb.push_back(31'(-2));
      end else begin
        sb.push_back(31'd14); sb.push_back(31'd20);
        sb.push_back(31'(-2)); sb.push_back(31'(-2));
      end
      wait_done(ok);
      nvec++;
      if (ok !== 1'b1) begin
        nerr++;
        $display("FAIL multi%0d_done: done=%b, want 1", m, bus.done);
      end
      for (int i = 0; i < 4; i++) begin
        do_read(v, d);
        e = sb.pop_front();
        nvec++;
        if (v !== 1'b1 || d !== e) begin
          nerr++;
          $display("FAIL multi%0d_rd%0d: valid=%b out=%0d, want 1 %0d",
                   m, i, v, $signed(d), $signed(e));
        end
      end
    end
  endtask

  task automatic test_stride();
    logic v, ok;
    logic [OW-1:0] d, e;
    start_job(2, 3, 2'b00, 1'b0);
    wr_fil(1); wr_fil(2); wr_fil(3);
    load_row(5);
    sb.push_back(31'd14); sb.push_back(31'd26);
    wait_done(ok);
    nvec++;
    if (ok !== 1'b1) begin
      nerr++;
      $display("FAIL stride_done: done=%b, want 1", bus.done);
    end
    for (int i = 0; i < 3; i++) begin
      do_read(v, d);
      nvec++;
      if (i < 2) begin
        e = sb.pop_front();
        if (v !== 1'b1 || d !== e) begin
          nerr++;
          $display("FAIL stride_rd%0d: valid=%b out=%0d, want 1 %0d",
                   i, v, $signed(d), $signed(e));
        end
      end else if (v !== 1'b0) begin
        nerr++;
        $display("FAIL stride_extra: valid=%b, want 0", v);
      end
    end
  endtask

  task automatic test_acum();
    logic v, ok;
    logic [OW-1:0] d, e;
    start_job(1, 3, 2'b00, 1'b1);
    wr_fil(1); wr_fil(2); wr_fil(3);
    load_row(5);
    repeat (30) tick();
    do_read(v, d);
    nvec++;
    if (v !== 1'b0 || bus.done !== 1'b0) begin
      nerr++;
      $display("FAIL acum_stall: valid=%b done=%b, want 0 0", v, bus.done);
    end
    wr_ps(100); wr_ps(200); wr_ps(300);
    sb.push_back(31'd114); sb.push_back(31'd220); sb.push_back(31'd326);
    wait_done(ok);
    nvec++;
    if (ok !== 1'b1) begin
      nerr++;
      $display("FAIL acum_done: done=%b, want 1", bus.done);
    end
    for (int i = 0; i < 3; i++) begin
      do_read(v, d);
      e = sb.pop_front();
      nvec++;
      if (v !== 1'b1 || d !== e) begin
        nerr++;
        $display("FAIL acum_rd%0d: valid=%b out=%0d, want 1 %0d",
                 i, v, $signed(d), $signed(e));
      end
    end
  endtask

  task automatic test_edges();
    logic v, ok;
    logic [OW-1:0] d, e;
    int cnt;
    start_job(1, 1, 2'b00, 1'b0);
    wr_fil(2);
    for (int i = 0; i < 4; i++) wr_fil(9);
    nvec++;
    if (bus.ready_fil !== 1'b1) begin
      nerr++;
      $display("FAIL fil_ready5: ready_fil=%b, want 1", bus.ready_fil);
    end
    wr_fil(9);
    nvec++;
    if (bus.ready_fil !== 1'b0) begin
      nerr++;
      $display("FAIL fil_ready6: ready_fil=%b, want 0", bus.ready_fil);
    end
    wr_fil(9);
    nvec++;
    if (bus.ready_fil !== 1'b0) begin
      nerr++;
      $display("FAIL fil_ready7: ready_fil=%b, want 0", bus.ready_fil);
    end
    bus.data_in_ifm = {1'b0, 1'b0, 16'd5};
    bus.w_en_ifm = 1'b1;
    repeat (20) tick();
    bus.w_en_ifm = 1'b0;
    tick();
    wr_ifm(7, 1'b0, 1'b1);
    sb.push_back(31'd10); sb.push_back(31'd14);
    wait_done(ok);
    nvec++;
    if (ok !== 1'b1) begin
      nerr++;
      $display("FAIL edge_done: done=%b, want 1", bus.done);
    end
    cnt = 0;
    d = '0;
    bus.r_en = 1'b1;
    repeat (120) begin
      tick();
      if (bus.valid === 1'b1) begin
        cnt++;
        d = bus.out;
      end
    end
    bus.r_en = 1'b0;
    tick();
    e = sb.pop_front();
    nvec++;
    if (cnt != 1 || d !== e) begin
      nerr++;
      $display("FAIL ren_held: pulses=%0d out=%0d, want 1 %0d",
               cnt, $signed(d), $signed(e));
    end
    do_read(v, d);
    e = sb.pop_front();
    nvec++;
    if (v !== 1'b1 || d !== e) begin
      nerr++;
      $display("FAIL edge_rd2: valid=%b out=%0d, want 1 %0d",
               v, $signed(d), $signed(e));
    end
    do_read(v, d);
    nvec++;
    if (v !== 1'b0) begin
      nerr++;
      $display("FAIL edge_extra: valid=%b, want 0 (one ifm write only)", v);
    end
  endtask

  task automatic test_reset_mid();
    logic v, ok;
    logic [OW-1:0] d, e;
    start_job(1, 3, 2'b00, 1'b0);
    wr_fil(1); wr_fil(2); wr_fil(3);
    wr_ifm(1, 1'b1, 1'b0); wr_ifm(2, 1'b0, 1'b0);
    wr_ifm(3, 1'b0, 1'b0); wr_ifm(4, 1'b0, 1'b0);
    repeat (5) tick();
    do_read(v, d);
    nvec++;
    if (v !== 1'b1 || d !== 31'd14) begin
      nerr++;
      $display("FAIL mid_pre: valid=%b out=%0d, want 1 14", v, $signed(d));
    end
    rst_n = 1'b0;
    #1;
    nvec++;
    if (bus.out !== '0 || bus.valid !== 1'b0 || bus.done !== 1'b0 ||
        {bus.ready_ifm, bus.ready_fil, bus.ready_psum} !== 3'b111) begin
      nerr++;
      $display("FAIL mid_reset: out=%0d valid=%b done=%b rdy=%b%b%b, want 0 0 0 111",
               bus.out, bus.valid, bus.done,
               bus.ready_ifm, bus.ready_fil, bus.ready_psum);
    end
    tick();
    rst_n = 1'b1;
    tick();
    start_job(1, 3, 2'b00, 1'b0);
    wr_fil(1); wr_fil(2); wr_fil(3);
    load_row(5);
    sb.push_back(31'd14); sb.push_back(31'd20); sb.push_back(31'd26);
    wait_done(ok);
    nvec++;
    if (ok !== 1'b1) begin
      nerr++;
      $display("FAIL mid_done: done=%b, want 1", bus.done);
    end
    for (int i = 0; i < 3; i++) begin
      do_read(v, d);
      e = sb.pop_front();
      nvec++;
      if (v !== 1'b1 || d !== e) begin
        nerr++;
        $display("FAIL mid_rd%0d: valid=%b out=%0d, want 1 %0d",
                 i, v, $signed(d), $signed(e));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_stride();
    test_acum();
    test_edges();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
